// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader.
//   dumpState_e      : FSM states of the dump sequencer
//   DEFAULT_*        : default geometry (32 x 32-bit registers, 5-bit address)
//   regBytes()       : bytes needed to carry one register of a given width
//   BYTES_PER_REG    : bytes per register at the default width
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    CHKSUM,
    DONE
  } dumpState_e;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_DATA_W   = 32;

  // Register width is always a whole number of bytes.
  function automatic int regBytes(input int dataW);
    return dataW / 8;
  endfunction

  localparam int BYTES_PER_REG = regBytes(DEFAULT_DATA_W);

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the dump reader to the UART transmitter.
//   tx_data  : byte being offered
//   tx_valid : tx_data is valid; held until accepted
//   tx_ready : transmitter accepts the byte this cycle
// master = dump reader side, slave = transmitter side.
interface regfile_dump_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_reader_byte_serializer.sv
// Byte serializer: loads one DATA_W word and emits it LSB-first as bytes on a
// valid/ready stream.
//   clk, rst_n   : clock, synchronous active-low reset
//   load         : strobe, captures loadData and starts emitting
//   loadData     : parallel word to send
//   txReady      : downstream accepts the current byte
//   txValid      : a byte is being offered
//   txData       : current byte (low byte of the shift register)
//   lastAccepted : one-cycle pulse on the handshake of the final byte
module regfile_dump_reader_byte_serializer
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] loadData,
  input  logic              txReady,
  output logic              txValid,
  output logic [7:0]        txData,
  output logic              lastAccepted
);

  localparam int NBYTES = regBytes(DATA_W);
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

  logic [DATA_W-1:0] shiftReg;
  logic [BIDX_W-1:0] byteIdx;
  logic              active;
  logic              xfer;

  assign xfer         = active && txReady;
  assign txValid      = active;
  assign txData       = shiftReg[7:0];
  assign lastAccepted = xfer && (byteIdx == LAST_BYTE);

  // Shifting right on every accepted byte leaves the register at zero once
  // the word is gone, so txData reads 0 whenever nothing is offered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shiftReg <= '0;
      byteIdx  <= '0;
      active   <= 1'b0;
    end else if (load) begin
      shiftReg <= loadData;
      byteIdx  <= '0;
      active   <= 1'b1;
    end else if (xfer) begin
      shiftReg <= shiftReg >> 8;
      byteIdx  <= byteIdx + 1'b1;
      if (byteIdx == LAST_BYTE) active <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader. On start, reads x0..x(NUM_REGS-1) through one
// synchronous read port (1-cycle latency) and streams each register as
// little-endian bytes to the UART transmitter. busy stalls the core so the
// register file is not written mid-dump.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle dump request (ignored unless idle)
//   busy       : dump in progress / core stall request
//   done       : one-cycle pulse after the final byte handshake
//   rd_addr    : register-file read address
//   rd_data    : register-file read data, valid one cycle after rd_addr
//   txIf       : byte stream to the transmitter (master side)
// Build option REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum byte of all
// transmitted data bytes to the stream.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      rd_data,
  regfile_dump_reader_if.master  txIf
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam dumpState_e AFTER_LAST = CHKSUM;
`else
  localparam dumpState_e AFTER_LAST = DONE;
`endif

  dumpState_e        state, stateNext;
  logic [ADDR_W-1:0] regIdx, regIdxNext;
  logic              serLoad;
  logic              serValid;
  logic              serLast;
  logic [7:0]        serData;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      regIdx <= '0;
    end else begin
      state  <= stateNext;
      regIdx <= regIdxNext;
    end
  end

  // The read address is the register index itself: it changes on entry to
  // ADDR, the RAM samples it at the end of ADDR and rd_data is captured at
  // the end of WAIT.
  always_comb begin
    stateNext  = state;
    regIdxNext = regIdx;
    serLoad    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext  = ADDR;
          regIdxNext = '0;
        end
      end
      ADDR: stateNext = WAIT;
      WAIT: begin
        serLoad   = 1'b1;
        stateNext = SEND;
      end
      SEND: begin
        if (serLast) begin
          if (regIdx == LAST_REG) begin
            stateNext = AFTER_LAST;
          end else begin
            regIdxNext = regIdx + 1'b1;
            stateNext  = ADDR;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CHKSUM: begin
        if (txIf.tx_ready) stateNext = DONE;
      end
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign rd_addr = regIdx;
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

  regfile_dump_reader_byte_serializer #(
    .DATA_W(DATA_W)
  ) uSer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (serLoad),
    .loadData    (rd_data),
    .txReady     (txIf.tx_ready),
    .txValid     (serValid),
    .txData      (serData),
    .lastAccepted(serLast)
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [7:0] csum;

  // Only data bytes are folded in; the checksum byte itself is not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (serValid && txIf.tx_ready) begin
      csum <= csum ^ serData;
    end
  end

  assign txIf.tx_valid = serValid || (state == CHKSUM);
  assign txIf.tx_data  = (state == CHKSUM) ? csum : serData;
`else
  assign txIf.tx_valid = serValid;
  assign txIf.tx_data  = serData;
`endif

endmodule
